// File: rtl/lms_dac_serializer.sv
// lms_dac_serializer
//   Output stage of the LMS adaptive filter. Each 16-bit signed sample strobed in
//   is converted to offset binary, prefixed with an 8-bit DAC control word, and
//   shifted MSB first to an external serial DAC as a 24-bit SPI-style frame.
//   A one-deep pending buffer holds a sample that arrives while a frame is in
//   flight. A newer sample replaces an older pending one, and each such overrun
//   is reported as a pulse and counted.
//
// Ports
//   clk_i           in   1   system clock, rising edge
//   rst_n_i         in   1   asynchronous active-low reset
//   sample_i        in   16  signed sample (two's complement)
//   sample_valid_i  in   1   one-cycle strobe qualifying sample_i
//   dac_sclk_o      out  1   serial clock, idle low, DAC samples on rising edge
//   dac_sync_n_o    out  1   frame select, active low
//   dac_din_o       out  1   serial data, MSB first
//   busy_o          out  1   high whenever a frame is being started/sent/closed
//   overrun_o       out  1   high in the cycle a pending sample is overwritten
//   overrun_cnt_o   out  8   saturating overrun count since reset
module lms_dac_serializer #(
    parameter int          CLK_DIV   = 1,
    parameter logic [7:0]  CTRL_WORD = 8'h00
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic signed [15:0] sample_i,
    input  logic               sample_valid_i,
    output logic               dac_sclk_o,
    output logic               dac_sync_n_o,
    output logic               dac_din_o,
    output logic               busy_o,
    output logic               overrun_o,
    output logic [7:0]         overrun_cnt_o
);

    localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PHASE_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Offset-binary conversion: flipping the sign bit maps -32768..32767 onto 0..65535.
    function automatic logic [23:0] build_frame(input logic signed [15:0] s);
        return {CTRL_WORD, ~s[15], s[14:0]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Control state (asynchronously reset)
    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            low_q,   low_d;     // 0: SCLK high half of a bit, 1: low half
    logic [4:0]      bit_q,   bit_d;
    logic            pend_q,  pend_d;
    logic [7:0]      cnt_q,   cnt_d;

    // Data path (no reset needed; outputs are gated by state)
    logic [23:0]        shreg_q, shreg_d;
    logic signed [15:0] pdata_q, pdata_d;

    logic phase_end;
    logic stop_end;
    logic overrun;

    assign phase_end = (phase_q == PHASE_LAST);
    assign stop_end  = (state_q == STOP) && phase_end;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        low_d   = low_q;
        bit_d   = bit_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        pdata_d = pdata_q;
        overrun = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (sample_valid_i) begin
                    shreg_d = build_frame(sample_i);
                    state_d = START;
                end
            end
            START: begin
                if (phase_end) begin
                    phase_d = '0;
                    low_d   = 1'b0;
                    bit_d   = 5'd23;
                    state_d = SHIFT;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (!low_q) begin
                        // Falling SCLK edge: present the next bit for the next rise.
                        low_d   = 1'b1;
                        shreg_d = {shreg_q[22:0], 1'b0};
                    end else begin
                        low_d = 1'b0;
                        if (bit_q == 5'd0) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            STOP: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (pend_q) begin
                        // Older pending sample goes first; a simultaneous strobe
                        // takes its place in the buffer without counting as overrun.
                        shreg_d = build_frame(pdata_q);
                        state_d = START;
                        pend_d  = sample_valid_i;
                        if (sample_valid_i) begin
                            pdata_d = sample_i;
                        end
                    end else if (sample_valid_i) begin
                        shreg_d = build_frame(sample_i);
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Buffer strobes that arrive mid-frame; newest sample wins.
        if ((state_q != IDLE) && !stop_end && sample_valid_i) begin
            pdata_d = sample_i;
            pend_d  = 1'b1;
            if (pend_q) begin
                overrun = 1'b1;
                cnt_d   = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            phase_q <= '0;
            low_q   <= 1'b0;
            bit_q   <= 5'd0;
            pend_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            low_q   <= low_d;
            bit_q   <= bit_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
        pdata_q <= pdata_d;
    end

    // Outputs decode directly from state so an asynchronous reset idles them at once.
    assign busy_o        = (state_q != IDLE);
    assign dac_sync_n_o  = !((state_q == START) || (state_q == SHIFT));
    assign dac_sclk_o    = (state_q == SHIFT) && !low_q;
    assign dac_din_o     = ((state_q == START) || (state_q == SHIFT)) ? shreg_q[23] : 1'b0;
    assign overrun_o     = overrun;
    assign overrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_lms_dac_serializer.sv
module tb_lms_dac_serializer;

    typedef struct {
        logic [23:0] w;
        int          bits;
        int          low;
        int          gap;
    } frm_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] sample = '0;
    logic               valid = 1'b0;

    wire [1:0] sclk_w, sync_w, din_w, busy_w, ovr_w;
    wire [7:0] cnt0, cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lms_dac_serializer #(.CLK_DIV(1), .CTRL_WORD(8'h00)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .sample_i(sample), .sample_valid_i(valid),
        .dac_sclk_o(sclk_w[0]), .dac_sync_n_o(sync_w[0]), .dac_din_o(din_w[0]),
        .busy_o(busy_w[0]), .overrun_o(ovr_w[0]), .overrun_cnt_o(cnt0)
    );

    lms_dac_serializer #(.CLK_DIV(1), .CTRL_WORD(8'h30)) u_dut30 (
        .clk_i(clk), .rst_n_i(rst_n), .sample_i(sample), .sample_valid_i(valid),
        .dac_sclk_o(sclk_w[1]), .dac_sync_n_o(sync_w[1]), .dac_din_o(din_w[1]),
        .busy_o(busy_w[1]), .overrun_o(ovr_w[1]), .overrun_cnt_o(cnt1)
    );

    // ---------------- bus monitor: reconstructs frames from the serial pins
    frm_t fq0[$];
    frm_t fq1[$];
    logic [23:0] sh[2];
    int nbits[2], low_cnt[2], hi_cnt[2], last_gap[2], rises_frame[2];
    logic prev_sclk[2], prev_sync[2];
    int rise_total = 0;
    int ovr_seen   = 0;
    int cnt_err    = 0;

    function automatic frm_t mk(input logic [23:0] w, input int b, input int l, input int g);
        frm_t f;
        f.w = w; f.bits = b; f.low = l; f.gap = g;
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                prev_sclk[i]   <= 1'b0;
                prev_sync[i]   <= 1'b1;
                hi_cnt[i]      <= 0;
                low_cnt[i]     <= 0;
                nbits[i]       <= 0;
                sh[i]          <= '0;
                rises_frame[i] <= 0;
                last_gap[i]    <= 0;
            end
            rise_total <= 0;
            ovr_seen   <= 0;
        end else begin
            // counter must equal the number of pulses seen so far, clipped at 255
            if (cnt0 !== ((ovr_seen > 255) ? 8'd255 : 8'(ovr_seen))) cnt_err <= cnt_err + 1;
            if (ovr_w[0]) ovr_seen <= ovr_seen + 1;
            for (int i = 0; i < 2; i++) begin
                if (sclk_w[i] && !prev_sclk[i]) begin
                    sh[i]          <= {sh[i][22:0], din_w[i]};
                    nbits[i]       <= nbits[i] + 1;
                    rises_frame[i] <= rises_frame[i] + 1;
                    if (i == 0) rise_total <= rise_total + 1;
                end
                if (sync_w[i] && !prev_sync[i]) begin
                    if (i == 0) fq0.push_back(mk(sh[i], nbits[i], low_cnt[i], last_gap[i]));
                    else        fq1.push_back(mk(sh[i], nbits[i], low_cnt[i], last_gap[i]));
                    hi_cnt[i] <= 1;
                end else if (sync_w[i]) begin
                    hi_cnt[i] <= hi_cnt[i] + 1;
                end else if (prev_sync[i]) begin
                    last_gap[i]    <= hi_cnt[i];
                    low_cnt[i]     <= 1;
                    nbits[i]       <= 0;
                    sh[i]          <= '0;
                    rises_frame[i] <= 0;
                end else begin
                    low_cnt[i] <= low_cnt[i] + 1;
                end
                prev_sclk[i] <= sclk_w[i];
                prev_sync[i] <= sync_w[i];
            end
        end
    end

    // ---------------- reference: frame = control prefix, then sample + 32768 mod 65536
    function automatic logic [23:0] exp_frame(input logic [7:0] ctrl, input logic signed [15:0] s);
        int code;
        code = int'(s) + 32768;
        return {ctrl, code[15:0]};
    endfunction

    // ---------------- stimulus helpers
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fq0.delete();
        fq1.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic signed [15:0] s);
        @(posedge clk); #1;
        sample = s;
        valid  = 1'b1;
        @(posedge clk); #1;
        valid  = 1'b0;
        sample = 16'($urandom);
    endtask

    task automatic get_frame(input int inst, output frm_t f, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        f  = mk('0, 0, 0, 0);
        while (!ok && n < 300) begin
            @(negedge clk); #1;
            if (inst == 0 && fq0.size() > 0) begin f = fq0.pop_front(); ok = 1'b1; end
            if (inst == 1 && fq1.size() > 0) begin f = fq1.pop_front(); ok = 1'b1; end
            n++;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout inst=%0d: no frame within 300 cycles", inst);
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({sync_w[0], sclk_w[0], din_w[0], busy_w[0], cnt0} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: sync=%b sclk=%b din=%b busy=%b cnt=%0d, need 1 0 0 0 0",
                     sync_w[0], sclk_w[0], din_w[0], busy_w[0], cnt0);
        end
        do_reset();
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if ({sync_w[0], sclk_w[0], din_w[0], busy_w[0], ovr_w[0], cnt0} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_idle: sync=%b sclk=%b din=%b busy=%b ovr=%b cnt=%0d",
                     sync_w[0], sclk_w[0], din_w[0], busy_w[0], ovr_w[0], cnt0);
        end
        n_tests++;
        if (rise_total !== 0) begin
            n_fail++;
            $display("FAIL reset_no_sclk: got %0d sclk rises, need 0", rise_total);
        end
    endtask

    task automatic test_codes();
        logic signed [15:0] s[4];
        frm_t f;
        bit ok;
        s[0] = 16'sh0000; s[1] = 16'sh7FFF; s[2] = 16'sh8000; s[3] = 16'shFFFF;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(s[k]);
            repeat (58) @(posedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            get_frame(0, f, ok);
            if (ok) begin
                n_tests++;
                if (f.w !== exp_frame(8'h00, s[k]) || f.bits != 24 || f.low != 49) begin
                    n_fail++;
                    $display("FAIL code_%0d: frame=%h bits=%0d low=%0d, need %h 24 49",
                             k, f.w, f.bits, f.low, exp_frame(8'h00, s[k]));
                end
            end
        end
        n_tests++;
        if (cnt0 !== 8'd0) begin
            n_fail++;
            $display("FAIL code_no_overrun: cnt=%0d, need 0", cnt0);
        end
    endtask

    task automatic test_random();
        logic signed [15:0] exp_q[$];
        frm_t f;
        bit ok;
        logic signed [15:0] s;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            s = 16'($urandom);
            exp_q.push_back(s);
            send(s);
            repeat ($urandom_range(80, 50) - 2) @(posedge clk);
        end
        repeat (60) @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            get_frame(0, f, ok);
            s = exp_q.pop_front();
            if (ok) begin
                n_tests++;
                if (f.w !== exp_frame(8'h00, s) || f.bits != 24 || f.low != 49 || f.gap < 1) begin
                    n_fail++;
                    $display("FAIL random_%0d: frame=%h bits=%0d low=%0d gap=%0d, need %h 24 49 >=1",
                             k, f.w, f.bits, f.low, f.gap, exp_frame(8'h00, s));
                end
            end
        end
        n_tests++;
        if (ovr_seen != 0) begin
            n_fail++;
            $display("FAIL random_no_overrun: got %0d pulses, need 0", ovr_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] a, b;
        frm_t fa, fb;
        bit ok_a, ok_b;
        a = 16'($urandom);
        b = 16'($urandom);
        do_reset();
        send(a);
        repeat (8) @(posedge clk);
        send(b);
        get_frame(0, fa, ok_a);
        get_frame(0, fb, ok_b);
        if (ok_a && ok_b) begin
            n_tests++;
            if (fa.w !== exp_frame(8'h00, a) || fb.w !== exp_frame(8'h00, b)) begin
                n_fail++;
                $display("FAIL b2b_data: frames %h %h, need %h %h",
                         fa.w, fb.w, exp_frame(8'h00, a), exp_frame(8'h00, b));
            end
            n_tests++;
            if (fb.gap != 1 || fb.low != 49) begin
                n_fail++;
                $display("FAIL b2b_gap: gap=%0d low=%0d, need 1 49", fb.gap, fb.low);
            end
        end
        n_tests++;
        if (ovr_seen != 0 || cnt0 !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_overrun: pulses=%0d cnt=%0d, need 0 0", ovr_seen, cnt0);
        end
    endtask

    task automatic test_overrun();
        logic signed [15:0] a, b, c;
        frm_t fa, fc;
        bit ok_a, ok_c;
        a = 16'sh1111; b = 16'sh2222; c = 16'sh3333;
        do_reset();
        send(a);
        repeat (2) @(posedge clk);
        send(b);
        repeat (2) @(posedge clk);
        send(c);
        get_frame(0, fa, ok_a);
        get_frame(0, fc, ok_c);
        if (ok_a && ok_c) begin
            n_tests++;
            if (fa.w !== exp_frame(8'h00, a) || fc.w !== exp_frame(8'h00, c)) begin
                n_fail++;
                $display("FAIL overrun_frames: %h %h, need %h %h",
                         fa.w, fc.w, exp_frame(8'h00, a), exp_frame(8'h00, c));
            end
        end
        repeat (100) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (fq0.size() != 0) begin
            n_fail++;
            $display("FAIL overrun_dropped: %0d extra frames, need 0", fq0.size());
        end
        n_tests++;
        if (ovr_seen != 1 || cnt0 !== 8'd1) begin
            n_fail++;
            $display("FAIL overrun_count: pulses=%0d cnt=%0d, need 1 1", ovr_seen, cnt0);
        end
    endtask

    task automatic test_saturate();
        int err0;
        do_reset();
        err0 = cnt_err;
        @(posedge clk); #1;
        valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            sample = 16'($urandom);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        repeat (120) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (ovr_seen < 300 || cnt0 !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate: pulses=%0d cnt=%0d, need >=300 255", ovr_seen, cnt0);
        end
        n_tests++;
        if (cnt_err != err0) begin
            n_fail++;
            $display("FAIL saturate_track: %0d cycles with count off, need 0", cnt_err - err0);
        end
    endtask

    task automatic test_reset_midframe();
        frm_t f0, f1;
        bit ok0, ok1;
        int n;
        do_reset();
        send(16'sh1234);
        n = 0;
        while (rises_frame[0] < 10 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        n_tests++;
        if (rises_frame[0] < 10) begin
            n_fail++;
            $display("FAIL midframe_reach: got %0d rises, need 10", rises_frame[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sync_w, sclk_w, din_w, busy_w} !== {2'b11, 2'b00, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL midframe_async: sync=%b sclk=%b din=%b busy=%b, need 11 00 00 00",
                     sync_w, sclk_w, din_w, busy_w);
        end
        repeat (2) @(posedge clk);
        #1;
        fq0.delete();
        fq1.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        send(16'sh1234);
        get_frame(0, f0, ok0);
        get_frame(1, f1, ok1);
        if (ok0 && ok1) begin
            n_tests++;
            if (f0.w !== 24'h009234 || f0.bits != 24) begin
                n_fail++;
                $display("FAIL midframe_ctrl00: frame=%h bits=%0d, need 009234 24", f0.w, f0.bits);
            end
            n_tests++;
            if (f1.w !== 24'h309234 || f1.bits != 24) begin
                n_fail++;
                $display("FAIL midframe_ctrl30: frame=%h bits=%0d, need 309234 24", f1.w, f1.bits);
            end
        end
    endtask

    initial begin
        test_reset();
        test_codes();
        test_random();
        test_back_to_back();
        test_overrun();
        test_saturate();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
